// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response handshake between fetch stage and memory
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;
    modport master (output req, addr, input ready, rdata);
    modport slave (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing one-outstanding imem requests into an output slot plus skid entry
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        imem,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic [31:0]         instr_out,
    output logic [31:0]         pc_out,
    output logic                valid_out
);
    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
    state_t state, state_n;
    logic [31:0] addr_q, target_q, skid_instr, skid_pc;
    logic skid_valid, xfer, slot_free, fire;
    assign xfer      = imem.req && imem.ready;
    assign fire      = state == FETCH && xfer;
    assign slot_free = !valid_out || !stall;
    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state;
        unique case (state)
            FETCH:   state_n = redirect ? (xfer ? FETCH : DROP) : (xfer && !slot_free ? HOLD : FETCH);
            HOLD:    state_n = redirect || slot_free ? FETCH : HOLD;
            DROP:    state_n = xfer ? FETCH : DROP;
            default: state_n = FETCH;
        endcase
    end
    always_comb begin
        imem.req  = state != HOLD && reset;
        imem.addr = addr_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q     <= RESET_PC;
            target_q   <= RESET_PC;
            instr_out  <= '0;
            pc_out     <= '0;
            valid_out  <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
        end else if (redirect) begin
            valid_out  <= 1'b0;
            skid_valid <= 1'b0;
            target_q   <= redirect_pc;
            if (state == HOLD || xfer) addr_q <= redirect_pc;
        end else begin
            if (fire) addr_q <= addr_q + PC_STEP;
            if (state == DROP && xfer) addr_q <= target_q;
            if (fire && !slot_free) begin
                skid_instr <= imem.rdata;
                skid_pc    <= addr_q;
                skid_valid <= 1'b1;
            end
            if (slot_free) begin
                valid_out <= fire || (state == HOLD && skid_valid);
                if (fire) begin
                    instr_out <= imem.rdata;
                    pc_out    <= addr_q;
                end else if (state == HOLD) begin
                    instr_out  <= skid_instr;
                    pc_out     <= skid_pc;
                    skid_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios plus a memory-side scoreboard of delivered instructions
module tb_fetch_unit;
    logic clk, reset, ready, stall, redirect;
    logic [31:0] redirect_pc, instr_out, pc_out, instr2, pc2;
    logic valid_out, valid2;
    int vectors = 0, errors = 0;
    logic [63:0] sb[$];
    bit drop_next, prev_wait;
    logic [31:0] prev_addr;
    fetch_unit_if bus();
    fetch_unit_if bus2();
    function automatic logic [31:0] word(logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction
    assign bus.ready  = ready;
    assign bus.rdata  = word(bus.addr);
    assign bus2.ready = 1'b1;
    assign bus2.rdata = word(bus2.addr);
    fetch_unit dut (
        .clk(clk), .reset(reset), .imem(bus), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out)
    );
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(reset), .imem(bus2), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .instr_out(instr2), .pc_out(pc2), .valid_out(valid2)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            drop_next = 1'b0;
            prev_wait = 1'b0;
        end else begin
            if (valid_out && !stall && !redirect) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    check("sb_pc", pc_out, e[63:32]);
                    check("sb_instr", instr_out, e[31:0]);
                end
            end
            if (prev_wait && bus.req) check("addr_stable", bus.addr, prev_addr);
            if (redirect) begin
                sb.delete();
                drop_next = bus.req && !ready;
            end else if (bus.req && ready) begin
                if (drop_next) drop_next = 1'b0;
                else sb.push_back({bus.addr, word(bus.addr)});
            end
            prev_wait = bus.req && !ready;
            prev_addr = bus.addr;
        end
    end
    initial begin
        reset = 1'b0; ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (3) step();
        check("rst_req", 32'(bus.req), 0);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_pc", pc_out, 0);
        check("rst_instr", instr_out, 0);
        reset = 1'b1;
        #1;
        check("rel_req", 32'(bus.req), 1);
        check("rel_addr", bus.addr, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("s_addr", bus.addr, 32'(4 * (i + 1)));
            check("s_valid", 32'(valid_out), 1);
            check("s_pc", pc_out, 32'(4 * i));
            check("wrap_pc", pc2, 32'hFFFF_FFF8 + 32'(4 * i));
            check("wrap_instr", instr2, word(32'hFFFF_FFF8 + 32'(4 * i)));
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_req", 32'(bus.req), 0);
            check("hold_pc", pc_out, 32'd12);
            check("hold_valid", 32'(valid_out), 1);
            check("hold_addr", bus.addr, 32'd20);
        end
        stall = 1'b0;
        step();
        check("unstall_pc", pc_out, 32'd16);
        check("unstall_req", 32'(bus.req), 1);
        step();
        check("unstall_pc2", pc_out, 32'd20);
        redirect = 1'b1; redirect_pc = 32'd8;
        step();
        check("redir_valid", 32'(valid_out), 0);
        check("redir_addr", bus.addr, 32'd8);
        redirect = 1'b0; ready = 1'b0;
        step();
        check("wait_addr", bus.addr, 32'd8);
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        check("drop_addr", bus.addr, 32'd8);
        check("drop_req", 32'(bus.req), 1);
        redirect = 1'b0;
        repeat (2) step();
        check("drop_addr2", bus.addr, 32'd8);
        ready = 1'b1;
        step();
        check("drop_new_addr", bus.addr, 32'h100);
        check("drop_valid", 32'(valid_out), 0);
        step();
        check("tgt_valid", 32'(valid_out), 1);
        check("tgt_pc", pc_out, 32'h100);
        stall = 1'b1;
        step();
        check("skid_valid", 32'(valid_out), 1);
        check("skid_req", 32'(bus.req), 0);
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        check("flush_valid", 32'(valid_out), 0);
        check("flush_addr", bus.addr, 32'h200);
        redirect = 1'b0; stall = 1'b0;
        step();
        check("flush_first_pc", pc_out, 32'h200);
        check("flush_first_instr", instr_out, word(32'h200));
        step();
        check("flush_next_pc", pc_out, 32'h204);
        ready = 1'b0;
        step();
        check("mid_addr", bus.addr, 32'h208);
        reset = 1'b0;
        step();
        check("midrst_req", 32'(bus.req), 0);
        check("midrst_valid", 32'(valid_out), 0);
        reset = 1'b1; ready = 1'b1;
        #1;
        check("restart_addr", bus.addr, 32'h0);
        step();
        check("restart_pc", pc_out, 32'h0);
        check("restart_valid", 32'(valid_out), 1);
        for (int n = 0; n < 400; n++) begin
            ready = $urandom_range(0, 3) != 0;
            stall = $urandom_range(0, 3) == 0;
            redirect = $urandom_range(0, 19) == 0;
            redirect_pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            step();
        end
        ready = 1'b1; stall = 1'b0; redirect = 1'b0;
        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: the producer side of the IF/ID pipeline register.
- Owns the PC, issues requests to instruction memory over a req/ready handshake, and presents {instr, pc, valid} toward IF/ID.
- Obeys a stall (the inverse of the IF/ID enable) and branch/jump redirects from later stages.
- At most one memory request outstanding; a two-entry buffer (output slot plus skid entry) sustains one instruction per cycle.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset
PC_STEP   4              byte increment per sequential fetch

Ports:
clk          input   1   rising-edge clock, only clock
reset        input   1   synchronous, active-low reset (0 = reset, sampled on posedge clk)
imem_req     output  1   request valid toward instruction memory
imem_addr    output  32  request byte address; stable while imem_req=1 and imem_ready=0
imem_ready   input   1   request accepted and imem_rdata valid this cycle (qualified by imem_req)
imem_rdata   input   32  instruction word
stall        input   1   1 = downstream does not accept the output slot this cycle
redirect     input   1   1 = flush and restart fetch at redirect_pc
redirect_pc  input   32  redirect target
instr_out    output  32  instruction in output slot (registered)
pc_out       output  32  address of instr_out (registered)
valid_out    output  1   output slot holds a live instruction (registered)

Behaviour:
- Reset (reset=0 at posedge): pc=RESET_PC, addr_q=RESET_PC, state=FETCH.
- Reset clears instr_out=0, pc_out=0, valid_out=0 and skid buffer invalid.
- Reset mid-request abandons the request: imem_req is 0 while reset=0 and memory must tolerate this.
- imem_req = (state==FETCH || state==DROP) && reset==1. imem_addr = addr_q.
- Handshake: a transfer occurs on a cycle with imem_req=1 && imem_ready=1.
- imem_addr must not change while imem_req=1 and no transfer has occurred.
- slot_free = !valid_out || !stall. Downstream consumes the slot on a cycle with valid_out=1 && stall=0.
- States:
  - FETCH: request at addr_q.
    - On transfer with slot_free: load slot {imem_rdata, addr_q, valid=1}, addr_q += PC_STEP, stay FETCH.
    - On transfer with !slot_free: write skid {imem_rdata, addr_q}, addr_q += PC_STEP, go HOLD.
    - With no transfer and slot_free: clear valid_out when the slot was consumed.
  - HOLD: imem_req=0. When slot_free: move skid into slot, go FETCH. Otherwise hold everything.
  - DROP: a redirect arrived while a request was in flight. Keep the old address stable.
    - On transfer: discard rdata, addr_q = pending target, go FETCH.
- Redirect (priority over all other events, any state):
  - valid_out <= 0 and skid invalid, regardless of stall.
  - FETCH with imem_req=1 and no transfer this cycle: latch redirect_pc as pending target, go DROP.
  - FETCH with a transfer this cycle: discard rdata, addr_q = redirect_pc, stay FETCH.
  - HOLD: addr_q = redirect_pc, go FETCH.
  - DROP: overwrite pending target with redirect_pc. On the same cycle as a transfer, go FETCH with addr_q = redirect_pc.
- Latency: transfer at cycle N gives valid_out=1 at cycle N+1. Throughput is 1 instruction/cycle when imem_ready=1 and stall=0.
- Arithmetic: addr_q + PC_STEP is 32-bit modulo. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Slot data is unchanged while valid_out=1 && stall=1.

Test Plan:
- Reset, then imem_ready tied 1, stall=0: imem_addr 0,4,8,12 on consecutive cycles. valid_out=1 from cycle 2 with pc_out 0,4,8 trailing by one cycle.
- Stall asserted 3 cycles while streaming: one skid capture, imem_req=0 in HOLD, slot frozen. After release, pc_out continues with no gap and no duplicate.
- imem_ready low for 4 cycles at addr 8 while redirect_pc=32'h100 is asserted during the wait:
  - imem_addr stays 8 until ready, then goes to 32'h100.
  - The returned word for addr 8 never reaches valid_out.
- Redirect during stall with valid_out=1 and skid full: next cycle valid_out=0 and skid empty. The first valid_out after that carries pc_out=redirect_pc.
- RESET_PC=32'hFFFF_FFF8, streaming: pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- reset driven to 0 mid-wait (imem_ready=0): next cycle imem_req=0 and valid_out=0. After release, the fetch restarts at RESET_PC.
